// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter and its helpers.
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH_DEFAULT   = 32;
  localparam int LSB_ID_WIDTH_DEFAULT = 4;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_RUN  = 2'd1,
    ST_LS_RUN  = 2'd2,
    ST_IO_WAIT = 2'd3
  } arb_state_t;

  // funct3 load codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // addr[17:16] value that marks the memory-mapped IO region
  localparam logic [1:0] IO_REGION = 2'b11;

  // Engine length field (bytes minus one) from the access size bits
  function automatic logic [1:0] len_for_size(input logic [1:0] size_bits);
    case (size_bits)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic is_io_region(input logic [1:0] region_bits);
    return region_bits == IO_REGION;
  endfunction

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// Combinational load-result extension: picks the byte/half/word from the
// little-endian engine data and sign- or zero-extends it by funct3.
module mem_arbiter_load_extend
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Extension select by load type; unknown codes pass the word through
  always_comb begin
    ext = raw;
    case (funct3)
      F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
      F3_LBU:  ext = {24'd0, raw[7:0]};
      F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
      F3_LHU:  ext = {16'd0, raw[15:0]};
      F3_LW:   ext = raw;
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Request scheduler between the icache miss path and the load/store buffer,
// issuing one transaction at a time to the byte-serial memory engine.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
  parameter int LSB_ID_WIDTH = LSB_ID_WIDTH_DEFAULT,
  parameter int FAIR_LIMIT   = 4
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic                    io_buffer_full,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_busy,
  output logic                    if_done,
  output logic [ADDR_WIDTH-1:0]   if_done_addr,
  output logic [31:0]             if_data,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [31:0]             ls_wdata,
  input  logic [2:0]              ls_type,
  input  logic [LSB_ID_WIDTH-1:0] ls_id,
  output logic                    ls_busy,
  output logic                    ls_done,
  output logic [LSB_ID_WIDTH-1:0] ls_done_id,
  output logic [31:0]             ls_rdata,
  output logic                    eng_start,
  output logic [ADDR_WIDTH-1:0]   eng_addr,
  output logic                    eng_we,
  output logic [31:0]             eng_wdata,
  output logic [1:0]              eng_len,
  input  logic                    eng_done,
  input  logic [31:0]             eng_rdata
);

  localparam int               CNT_W    = $clog2(FAIR_LIMIT + 1);
  localparam logic [CNT_W-1:0] FAIR_MAX = CNT_W'(FAIR_LIMIT);

  arb_state_t state_reg;

  // IF slot
  logic                    if_valid_reg;
  logic [ADDR_WIDTH-1:0]   if_addr_reg;
  logic                    if_kill_reg;   // in-flight fetch was flushed

  // LS slot
  logic                    ls_valid_reg;
  logic                    ls_we_reg;
  logic [ADDR_WIDTH-1:0]   ls_addr_reg;
  logic [31:0]             ls_wdata_reg;
  logic [2:0]              ls_type_reg;
  logic [LSB_ID_WIDTH-1:0] ls_id_reg;
  logic                    ls_kill_reg;   // in-flight load was flushed

  logic                    io_return_reg; // fetch was granted out of IO_WAIT
  logic [CNT_W-1:0]        fair_cnt_reg;

  // A request is taken into an empty slot; arbitration sees the slot as it
  // will be after this edge, so a fresh request can be granted on capture.
  logic                    if_take, ls_take;
  logic                    if_avail, ls_avail;
  logic [ADDR_WIDTH-1:0]   if_cur_addr;
  logic                    ls_cur_we;
  logic [ADDR_WIDTH-1:0]   ls_cur_addr;
  logic [31:0]             ls_cur_wdata;
  logic [2:0]              ls_cur_type;
  logic                    ls_io_blocked;
  logic                    fair_hit;
  logic [31:0]             ls_ext;

  assign if_take  = if_req && !if_valid_reg && !flush;
  assign ls_take  = ls_req && !ls_valid_reg && !flush;

  // flush removes a pending fetch or load from contention, never a store
  assign if_avail = (if_valid_reg && !flush) || if_take;
  assign ls_avail = ls_valid_reg ? (ls_we_reg || !flush) : ls_take;

  assign if_cur_addr   = if_valid_reg ? if_addr_reg  : if_addr;
  assign ls_cur_we     = ls_valid_reg ? ls_we_reg    : ls_we;
  assign ls_cur_addr   = ls_valid_reg ? ls_addr_reg  : ls_addr;
  assign ls_cur_wdata  = ls_valid_reg ? ls_wdata_reg : ls_wdata;
  assign ls_cur_type   = ls_valid_reg ? ls_type_reg  : ls_type;
  assign ls_io_blocked = ls_cur_we && is_io_region(ls_cur_addr[17:16]) && io_buffer_full;
  assign fair_hit      = fair_cnt_reg >= FAIR_MAX;

  assign if_busy = if_valid_reg;
  assign ls_busy = ls_valid_reg;

  mem_arbiter_load_extend u_load_extend (
    .funct3 (ls_type_reg),
    .raw    (eng_rdata),
    .ext    (ls_ext)
  );

  // Slot capture, flush handling, arbitration FSM and registered outputs
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_reg     <= ST_IDLE;
      if_valid_reg  <= 1'b0;
      if_addr_reg   <= '0;
      if_kill_reg   <= 1'b0;
      ls_valid_reg  <= 1'b0;
      ls_we_reg     <= 1'b0;
      ls_addr_reg   <= '0;
      ls_wdata_reg  <= '0;
      ls_type_reg   <= '0;
      ls_id_reg     <= '0;
      ls_kill_reg   <= 1'b0;
      io_return_reg <= 1'b0;
      fair_cnt_reg  <= '0;
      if_done       <= 1'b0;
      if_done_addr  <= '0;
      if_data       <= '0;
      ls_done       <= 1'b0;
      ls_done_id    <= '0;
      ls_rdata      <= '0;
      eng_start     <= 1'b0;
      eng_addr      <= '0;
      eng_we        <= 1'b0;
      eng_wdata     <= '0;
      eng_len       <= '0;
    end else if (rdy_in) begin
      eng_start <= 1'b0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;

      if (if_take) begin
        if_valid_reg <= 1'b1;
        if_addr_reg  <= if_addr;
      end
      if (ls_take) begin
        ls_valid_reg <= 1'b1;
        ls_we_reg    <= ls_we;
        ls_addr_reg  <= ls_addr;
        ls_wdata_reg <= ls_wdata;
        ls_type_reg  <= ls_type;
        ls_id_reg    <= ls_id;
      end

      if (flush) begin
        if (if_valid_reg) begin
          if_valid_reg <= 1'b0;
          if (state_reg == ST_IF_RUN) if_kill_reg <= 1'b1;
        end
        if (ls_valid_reg && !ls_we_reg) begin
          ls_valid_reg <= 1'b0;
          if (state_reg == ST_LS_RUN) ls_kill_reg <= 1'b1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (if_avail && (fair_hit || !ls_avail)) begin
            eng_start     <= 1'b1;
            eng_addr      <= if_cur_addr;
            eng_we        <= 1'b0;
            eng_wdata     <= '0;
            eng_len       <= 2'd3;
            fair_cnt_reg  <= '0;
            io_return_reg <= 1'b0;
            state_reg     <= ST_IF_RUN;
          end else if (ls_avail) begin
            if (ls_io_blocked) begin
              state_reg <= ST_IO_WAIT;
            end else begin
              eng_start <= 1'b1;
              eng_addr  <= ls_cur_addr;
              eng_we    <= ls_cur_we;
              eng_wdata <= ls_cur_wdata;
              eng_len   <= len_for_size(ls_cur_type[1:0]);
              if (if_avail && !fair_hit) fair_cnt_reg <= fair_cnt_reg + 1'b1;
              state_reg <= ST_LS_RUN;
            end
          end
        end

        ST_IO_WAIT: begin
          if (!io_buffer_full && !(fair_hit && if_avail)) begin
            eng_start <= 1'b1;
            eng_addr  <= ls_addr_reg;
            eng_we    <= 1'b1;
            eng_wdata <= ls_wdata_reg;
            eng_len   <= len_for_size(ls_type_reg[1:0]);
            if (if_avail && !fair_hit) fair_cnt_reg <= fair_cnt_reg + 1'b1;
            state_reg <= ST_LS_RUN;
          end else if (if_avail) begin
            eng_start     <= 1'b1;
            eng_addr      <= if_cur_addr;
            eng_we        <= 1'b0;
            eng_wdata     <= '0;
            eng_len       <= 2'd3;
            fair_cnt_reg  <= '0;
            io_return_reg <= 1'b1;
            state_reg     <= ST_IF_RUN;
          end
        end

        ST_IF_RUN: begin
          if (eng_done) begin
            state_reg     <= io_return_reg ? ST_IO_WAIT : ST_IDLE;
            io_return_reg <= 1'b0;
            if_kill_reg   <= 1'b0;
            if (!if_kill_reg && !flush) begin
              if_done      <= 1'b1;
              if_done_addr <= eng_addr;
              if_data      <= eng_rdata;
              if_valid_reg <= 1'b0;
            end
          end
        end

        ST_LS_RUN: begin
          if (eng_done) begin
            state_reg   <= ST_IDLE;
            ls_kill_reg <= 1'b0;
            if (!ls_kill_reg && (ls_we_reg || !flush)) begin
              ls_done      <= 1'b1;
              ls_done_id   <= ls_id_reg;
              ls_rdata     <= ls_we_reg ? 32'd0 : ls_ext;
              ls_valid_reg <= 1'b0;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase

      // flush restarts the fairness window regardless of any grant this edge
      if (flush) fair_cnt_reg <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, inline checks.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_busy;
  logic        if_done;
  logic [31:0] if_done_addr;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [2:0]  ls_type;
  logic [3:0]  ls_id;
  logic        ls_busy;
  logic        ls_done;
  logic [3:0]  ls_done_id;
  logic [31:0] ls_rdata;
  logic        eng_start;
  logic [31:0] eng_addr;
  logic        eng_we;
  logic [31:0] eng_wdata;
  logic [1:0]  eng_len;
  logic        eng_done;
  logic [31:0] eng_rdata;

  int total = 0;
  int bad   = 0;

  // load vectors: type, engine data, expected result, expected eng_len
  logic [2:0]  ld_type [5] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010};
  logic [31:0] ld_raw  [5] = '{32'h0000_00F0, 32'h0000_F0F0, 32'h0000_8001, 32'h1234_56F0, 32'h8765_4321};
  logic [31:0] ld_exp  [5] = '{32'hFFFF_FFF0, 32'h0000_F0F0, 32'hFFFF_8001, 32'h0000_00F0, 32'h8765_4321};
  logic [1:0]  ld_len  [5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd3};

  mem_arbiter #(
    .ADDR_WIDTH   (32),
    .LSB_ID_WIDTH (4),
    .FAIR_LIMIT   (4)
  ) dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush          (flush),
    .io_buffer_full (io_buffer_full),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_busy        (if_busy),
    .if_done        (if_done),
    .if_done_addr   (if_done_addr),
    .if_data        (if_data),
    .ls_req         (ls_req),
    .ls_we          (ls_we),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_type        (ls_type),
    .ls_id          (ls_id),
    .ls_busy        (ls_busy),
    .ls_done        (ls_done),
    .ls_done_id     (ls_done_id),
    .ls_rdata       (ls_rdata),
    .eng_start      (eng_start),
    .eng_addr       (eng_addr),
    .eng_we         (eng_we),
    .eng_wdata      (eng_wdata),
    .eng_len        (eng_len),
    .eng_done       (eng_done),
    .eng_rdata      (eng_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: bench still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (eng_start === 1'b1) seen = 1'b1;
      else tick();
    end
    if (!seen && eng_start === 1'b1) seen = 1'b1;
  endtask

  task automatic serve(input logic [31:0] data);
    eng_done  = 1'b1;
    eng_rdata = data;
    tick();
    eng_done  = 1'b0;
  endtask

  task automatic drain;
    bit seen;
    for (int r = 0; r < 4; r++) begin
      wait_start(6, seen);
      if (seen) serve(32'h0);
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0;
    ls_wdata = '0; ls_type = '0; ls_id = '0; eng_done = 1'b0; eng_rdata = '0;
    tick(); tick();
    total++;
    if ({if_busy, if_done, if_done_addr, if_data, ls_busy, ls_done, ls_done_id, ls_rdata,
         eng_start, eng_addr, eng_we, eng_wdata, eng_len} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b/%b start=%b addr=%h len=%0d, required all zero",
               if_busy, ls_busy, eng_start, eng_addr, eng_len);
    end
    rst_in = 1'b1;
    tick();
    $display("reset: released");
  endtask

  task automatic test_ifetch;
    if_req = 1'b1; if_addr = 32'h1000;
    tick();
    if_req = 1'b0;
    total++;
    if ({eng_start, eng_we, eng_len, eng_addr, if_busy} !== {1'b1, 1'b0, 2'd3, 32'h1000, 1'b1}) begin
      bad++;
      $display("FAIL if_start: got start=%b we=%b len=%0d addr=%h busy=%b, required 1 0 3 00001000 1",
               eng_start, eng_we, eng_len, eng_addr, if_busy);
    end
    tick();
    total++;
    if ({eng_start, eng_addr} !== {1'b0, 32'h1000}) begin
      bad++;
      $display("FAIL if_start_pulse: got start=%b addr=%h, required 0 00001000", eng_start, eng_addr);
    end
    serve(32'h00A0_0093);
    total++;
    if ({if_done, if_data, if_done_addr, if_busy} !== {1'b1, 32'h00A0_0093, 32'h1000, 1'b0}) begin
      bad++;
      $display("FAIL if_done: got done=%b data=%h addr=%h busy=%b, required 1 00a00093 00001000 0",
               if_done, if_data, if_done_addr, if_busy);
    end
    tick();
    total++;
    if (if_done !== 1'b0) begin
      bad++;
      $display("FAIL if_done_pulse: got %b, required 0", if_done);
    end
    $display("ifetch: addr=%h data=%h", if_done_addr, if_data);
  endtask

  task automatic test_load_extend;
    for (int k = 0; k < 5; k++) begin
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20; ls_type = ld_type[k]; ls_id = 4'(k + 1);
      tick();
      ls_req = 1'b0;
      total++;
      if ({eng_start, eng_we, eng_len, eng_addr} !== {1'b1, 1'b0, ld_len[k], 32'h20}) begin
        bad++;
        $display("FAIL load%0d_start: got start=%b we=%b len=%0d addr=%h, required 1 0 %0d 00000020",
                 k, eng_start, eng_we, eng_len, eng_addr, ld_len[k]);
      end
      serve(ld_raw[k]);
      total++;
      if ({ls_done, ls_done_id, ls_rdata} !== {1'b1, 4'(k + 1), ld_exp[k]}) begin
        bad++;
        $display("FAIL load%0d_result: got done=%b id=%0d rdata=%h, required 1 %0d %h",
                 k, ls_done, ls_done_id, ls_rdata, k + 1, ld_exp[k]);
      end
      $display("load: type=%b raw=%h rdata=%h", ld_type[k], ld_raw[k], ls_rdata);
    end
  endtask

  task automatic test_fairness;
    bit          seen;
    logic [5:0]  if_turn;
    logic [31:0] exp_addr;
    if_turn = 6'b010000;
    if_req = 1'b1; if_addr = 32'h2000;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; ls_type = 3'b010; ls_id = 4'd5;
    for (int k = 0; k < 6; k++) begin
      wait_start(20, seen);
      exp_addr = if_turn[k] ? 32'h2000 : 32'h40;
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL fair_grant%0d: got no eng_start in 20 cycles, required addr %h", k, exp_addr);
      end else begin
        if (k == 5) begin if_req = 1'b0; ls_req = 1'b0; end
        if (eng_addr !== exp_addr) begin
          bad++;
          $display("FAIL fair_grant%0d: got addr %h, required %h", k, eng_addr, exp_addr);
        end
        $display("fair: grant %0d addr=%h", k, eng_addr);
        serve(32'h0);
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    drain();
  endtask

  task automatic test_io_wait;
    int early;
    early = 0;
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0003_0000; ls_wdata = 32'hDEAD_BEEF;
    ls_type = 3'b010; ls_id = 4'd3;
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    if_req = 1'b1; if_addr = 32'h3000;
    total++;
    if ({eng_start, ls_busy} !== 2'b01) begin
      bad++;
      $display("FAIL io_hold: got start=%b ls_busy=%b, required 0 1", eng_start, ls_busy);
    end
    tick();
    if_req = 1'b0;
    total++;
    if ({eng_start, eng_we, eng_addr} !== {1'b1, 1'b0, 32'h3000}) begin
      bad++;
      $display("FAIL io_if_grant: got start=%b we=%b addr=%h, required 1 0 00003000",
               eng_start, eng_we, eng_addr);
    end
    serve(32'h1111_2222);
    total++;
    if ({if_done, if_data} !== {1'b1, 32'h1111_2222}) begin
      bad++;
      $display("FAIL io_if_done: got done=%b data=%h, required 1 11112222", if_done, if_data);
    end
    for (int c = 0; c < 7; c++) begin
      tick();
      if (eng_start === 1'b1) early++;
    end
    total++;
    if (early !== 0) begin
      bad++;
      $display("FAIL io_no_start: got %0d starts while full, required 0", early);
    end
    io_buffer_full = 1'b0;
    tick();
    total++;
    if ({eng_start, eng_we, eng_addr, eng_wdata, eng_len} !== {1'b1, 1'b1, 32'h0003_0000, 32'hDEAD_BEEF, 2'd3}) begin
      bad++;
      $display("FAIL io_store_start: got start=%b we=%b addr=%h wdata=%h len=%0d, required 1 1 00030000 deadbeef 3",
               eng_start, eng_we, eng_addr, eng_wdata, eng_len);
    end
    serve(32'h0);
    total++;
    if ({ls_done, ls_done_id, ls_busy} !== {1'b1, 4'd3, 1'b0}) begin
      bad++;
      $display("FAIL io_store_done: got done=%b id=%0d busy=%b, required 1 3 0", ls_done, ls_done_id, ls_busy);
    end
    $display("io: store to 00030000 acknowledged");
  endtask

  task automatic test_flush;
    int stray;
    stray = 0;
    // in-flight fetch plus pending load, both flushed
    if_req = 1'b1; if_addr = 32'h4000;
    tick();
    if_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h50; ls_type = 3'b010; ls_id = 4'd7;
    tick();
    ls_req = 1'b0;
    total++;
    if ({if_busy, ls_busy} !== 2'b11) begin
      bad++;
      $display("FAIL flush_pre: got if_busy=%b ls_busy=%b, required 1 1", if_busy, ls_busy);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if ({if_busy, ls_busy} !== 2'b00) begin
      bad++;
      $display("FAIL flush_slots: got if_busy=%b ls_busy=%b, required 0 0", if_busy, ls_busy);
    end
    serve(32'hBAD0_BAD0);
    if (if_done === 1'b1 || ls_done === 1'b1 || eng_start === 1'b1) stray++;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (if_done === 1'b1 || ls_done === 1'b1 || eng_start === 1'b1) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL flush_suppress: got %0d done/start events, required 0", stray);
    end
    // in-flight fetch plus pending store: the store survives
    if_req = 1'b1; if_addr = 32'h5000;
    tick();
    if_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h60; ls_wdata = 32'h1122_3344; ls_type = 3'b000; ls_id = 4'd9;
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    serve(32'h0);
    total++;
    if ({if_done, ls_busy} !== 2'b01) begin
      bad++;
      $display("FAIL flush_store_kept: got if_done=%b ls_busy=%b, required 0 1", if_done, ls_busy);
    end
    tick();
    total++;
    if ({eng_start, eng_we, eng_addr, eng_wdata, eng_len} !== {1'b1, 1'b1, 32'h60, 32'h1122_3344, 2'd0}) begin
      bad++;
      $display("FAIL flush_store_start: got start=%b we=%b addr=%h wdata=%h len=%0d, required 1 1 00000060 11223344 0",
               eng_start, eng_we, eng_addr, eng_wdata, eng_len);
    end
    serve(32'h0);
    total++;
    if ({ls_done, ls_done_id} !== {1'b1, 4'd9}) begin
      bad++;
      $display("FAIL flush_store_done: got done=%b id=%0d, required 1 9", ls_done, ls_done_id);
    end
    $display("flush: fetch and load suppressed, store acknowledged");
  endtask

  task automatic test_reset_mid;
    for (int r = 0; r < 2; r++) begin
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80; ls_type = 3'b010; ls_id = 4'd2;
      tick();
      ls_req = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
      #($urandom_range(1, 3));
      rst_in = 1'b0;
      #1;
      total++;
      if ({if_busy, if_done, if_done_addr, if_data, ls_busy, ls_done, ls_done_id, ls_rdata,
           eng_start, eng_addr, eng_we, eng_wdata, eng_len} !== '0) begin
        bad++;
        $display("FAIL reset_mid%0d: got ls_busy=%b addr=%h len=%0d, required all zero",
                 r, ls_busy, eng_addr, eng_len);
      end
      tick();
      rst_in = 1'b1;
      if_req = 1'b1; if_addr = 32'h7000 + 32'(r);
      tick();
      if_req = 1'b0;
      total++;
      if ({eng_start, eng_addr, eng_len} !== {1'b1, 32'h7000 + 32'(r), 2'd3}) begin
        bad++;
        $display("FAIL reset_mid%0d_next: got start=%b addr=%h len=%0d, required 1 %h 3",
                 r, eng_start, eng_addr, eng_len, 32'h7000 + 32'(r));
      end
      serve(32'hCAFE_0000 + 32'(r));
      total++;
      if ({if_done, if_data} !== {1'b1, 32'hCAFE_0000 + 32'(r)}) begin
        bad++;
        $display("FAIL reset_mid%0d_done: got done=%b data=%h, required 1 %h",
                 r, if_done, if_data, 32'hCAFE_0000 + 32'(r));
      end
      $display("reset_mid: round %0d recovered", r);
    end
  endtask

  task automatic test_rdy_hold;
    rdy_in = 1'b0;
    if_req = 1'b1; if_addr = 32'h6000;
    repeat (3) tick();
    total++;
    if ({eng_start, if_busy} !== 2'b00) begin
      bad++;
      $display("FAIL rdy_hold: got start=%b busy=%b, required 0 0", eng_start, if_busy);
    end
    rdy_in = 1'b1;
    tick();
    if_req = 1'b0;
    total++;
    if ({eng_start, eng_addr} !== {1'b1, 32'h6000}) begin
      bad++;
      $display("FAIL rdy_resume: got start=%b addr=%h, required 1 00006000", eng_start, eng_addr);
    end
    serve(32'h5555_AAAA);
    $display("rdy: fetch resumed data=%h", if_data);
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_load_extend();
    test_fairness();
    test_io_wait();
    test_flush();
    test_reset_mid();
    test_rdy_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
